fn_eval_stream_ctrl: RTL and testbench

//  Streaming valid/ready front/back-end for the fixed-latency float function pipeline
//  y = 0.5*x + x^2*cos((x-128)/128).

---
 rtl/fn_eval_stream_ctrl.sv | 95 +++++++++
 tb/tb_fn_eval_stream_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fn_eval_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency, non-stallable float function pipeline.
// In-flight samples are tracked by a tag shift register, results land in a FWFT FIFO, and credits throttle intake.
module fn_eval_stream_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PIPE_LATENCY = 16,
    parameter int unsigned FIFO_DEPTH   = 32,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] pipe_data,
    input  logic [WIDTH-1:0] pipe_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    credits_used,
    output logic             busy,
    output logic             ovf_err
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [PIPE_LATENCY:0] tag;
    logic [CW-1:0]         credits;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  wr_req;
    logic                  wr_en;

    // Handshake and FIFO write qualification, all from registered state.
    always_comb begin
        in_ready     = (credits < CW'(FIFO_DEPTH));
        out_valid    = (count != '0);
        out_data     = out_valid ? mem[rd_ptr] : '0;
        credits_used = credits;
        busy         = (credits != '0);
        accept       = in_valid & in_ready;
        pop          = out_valid & out_ready;
        fifo_full    = (count == CW'(FIFO_DEPTH));
        wr_req       = tag[PIPE_LATENCY];
        wr_en        = wr_req & ~fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag       <= '0;
            pipe_data <= '0;
            credits   <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_err   <= 1'b0;
        end else begin
            tag <= {tag[PIPE_LATENCY-1:0], accept};
            if (accept) begin
                pipe_data <= in_data;
            end
            if (wr_req & fifo_full) begin
                ovf_err <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Storage needs no reset; out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pipe_result;
        end
    end

endmodule

// File: tb/tb_fn_eval_stream_ctrl.sv
// Bench for fn_eval_stream_ctrl: delay-line pipeline stand-in (result = input + 1 ulp) and a queue-based
// behavioural model compared every cycle, plus directed literal checks.
module tb_fn_eval_stream_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned L  = 16;
    localparam int unsigned D  = 32;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  pipe_data;
    logic [W-1:0]  pipe_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] credits_used;
    logic          busy;
    logic          ovf_err;

    int total = 0;
    int bad   = 0;

    fn_eval_stream_ctrl #(.WIDTH(W), .PIPE_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_data(pipe_data), .pipe_result(pipe_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .credits_used(credits_used), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Free-running stand-in pipeline, deliberately not reset.
    logic [W-1:0] dl [L];
    always @(posedge clk) begin
        dl[0] <= pipe_data;
        for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
    end
    assign pipe_result = dl[L-1] + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credit count, pending results with due cycle, visible output queue.
    int           cyc = 0;
    int           m_cred = 0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] m_pipe = '0;
    int           pend_due[$];
    logic [W-1:0] pend_val[$];
    logic [W-1:0] outq[$];

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_cred = 0; m_ovf = 1'b0; m_pipe = '0;
            pend_due.delete(); pend_val.delete(); outq.delete();
        end else begin
            automatic bit acc = in_valid && (m_cred < D);
            automatic bit pp  = (outq.size() > 0) && out_ready;
            automatic bit full = (outq.size() == D);
            if (pp) void'(outq.pop_front());
            while (pend_due.size() > 0 && pend_due[0] == cyc) begin
                void'(pend_due.pop_front());
                if (full) m_ovf = 1'b1;
                else outq.push_back(pend_val.pop_front());
                if (full) void'(pend_val.pop_front());
            end
            if (acc) begin
                pend_due.push_back(cyc + L + 1);
                pend_val.push_back(in_data + 32'd1);
                m_pipe = in_data;
            end
            m_cred = m_cred + int'(acc) - int'(pp);
        end
        cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk("in_ready", 32'(in_ready), 32'(m_cred < D));
            chk("out_valid", 32'(out_valid), 32'(outq.size() > 0));
            if (outq.size() > 0) chk("out_data", out_data, outq[0]);
            chk("credits_used", 32'(credits_used), 32'(m_cred));
            chk("busy", 32'(busy), 32'(m_cred != 0));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("pipe_data", pipe_data, m_pipe);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, acc_cnt;
        // 1. reset held with in_valid high
        reset = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_credits", 32'(credits_used), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_pipe_data", pipe_data, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        step();

        // 2. single sample latency
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h4300_0000;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk("single_latency", 32'(n), 32'(L + 1));
        chk("single_data", out_data, 32'h4300_0001);
        repeat (3) step();

        // 3. 100 back-to-back samples
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 32'h3F80_0000 + 32'(i);
            if (!in_ready) chk("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (L + 5) step();
        chk("b2b_drained", 32'(credits_used), 32'd0);

        // 4. fill with consumer stalled
        out_ready = 1'b0; acc_cnt = 0;
        for (int i = 0; i < D + 10; i++) begin
            in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i);
            #0;
            if (in_ready) acc_cnt++;
            step();
        end
        chk("fill_accepts", 32'(acc_cnt), 32'(D));
        repeat (L + 3) step();
        chk("fill_credits", 32'(credits_used), 32'(D));
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_head", out_data, 32'hA000_0001);

        // 5. full, source and consumer both active: one pop frees a credit, then steady accept+pop
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'hB000_0000 + 32'(i);
            step();
            chk("full_credits", 32'(credits_used), 32'(D - 1));
        end
        in_valid = 1'b0;
        repeat (D + L + 5) step();
        chk("drain_credits", 32'(credits_used), 32'd0);
        chk("drain_ovf", 32'(ovf_err), 32'd0);

        // 6. reset mid-flight
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin in_data = 32'hC000_0000 + 32'(i); step(); end
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < L + 5; i++) begin
            step();
            chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
            chk("mid_rst_credits", 32'(credits_used), 32'd0);
        end

        // Random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (D + L + 5) step();
        chk("final_credits", 32'(credits_used), 32'd0);
        chk("final_ovf", 32'(ovf_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
